// File: rtl/sub_slice_sequencer.sv
// Drives one external 3-bit borrow subtractor slice, LSB slice first, to form a WIDTH-bit A-B.
// Define SUB_SEQ_ABS_RESULT_EN to add a NEGATE pass that reports negative results as magnitude.
module sub_slice_sequencer #(
    parameter int WIDTH = 9
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             neg,
    output logic [2:0]       slice_x,
    output logic [2:0]       slice_y,
    output logic             slice_bin,
    input  logic [2:0]       slice_diff,
    input  logic             slice_bout
);

    localparam int SLICES = WIDTH / 3;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

`ifdef SUB_SEQ_ABS_RESULT_EN
    typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEGATE, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] opa_reg, opb_reg, work_reg, diff_reg;
    logic [WIDTH-1:0] work_upd;
    logic [KW-1:0]    k_reg;
    logic             brw_reg, borrow_reg;
    logic [2:0]       opa_sl, opb_sl;
    logic             k_last;

    assign k_last     = (k_reg == K_LAST);
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

    // Working value with the current slice replaced by the slice result; the
    // final slice's write lands in diff on the same edge, so diff is valid with done.
    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_work
            assign work_upd[3*gi +: 3] = (k_reg == KW'(gi)) ? slice_diff : work_reg[3*gi +: 3];
        end
    endgenerate

`ifdef SUB_SEQ_ABS_RESULT_EN
    logic [2:0] work_sl;
    logic       neg_reg;
    assign neg = neg_reg;
`else
    assign neg = 1'b0;
`endif

    always_comb begin
        opa_sl = '0;
        opb_sl = '0;
`ifdef SUB_SEQ_ABS_RESULT_EN
        work_sl = '0;
`endif
        for (int i = 0; i < SLICES; i++) begin
            if (k_reg == KW'(i)) begin
                opa_sl = opa_reg[3*i +: 3];
                opb_sl = opb_reg[3*i +: 3];
`ifdef SUB_SEQ_ABS_RESULT_EN
                work_sl = work_reg[3*i +: 3];
`endif
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        slice_x    = 3'd0;
        slice_y    = 3'd0;
        slice_bin  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_SUB;
            end
            S_SUB: begin
                slice_x   = opa_sl;
                slice_y   = opb_sl;
                slice_bin = brw_reg;
                if (k_last) begin
`ifdef SUB_SEQ_ABS_RESULT_EN
                    state_next = slice_bout ? S_NEGATE : S_DONE;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef SUB_SEQ_ABS_RESULT_EN
            S_NEGATE: begin
                slice_x   = 3'd0;
                slice_y   = work_sl;
                slice_bin = brw_reg;
                if (k_last) state_next = S_DONE;
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            opa_reg    <= '0;
            opb_reg    <= '0;
            work_reg   <= '0;
            diff_reg   <= '0;
            k_reg      <= '0;
            brw_reg    <= 1'b0;
            borrow_reg <= 1'b0;
`ifdef SUB_SEQ_ABS_RESULT_EN
            neg_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        opa_reg <= a;
                        opb_reg <= b;
                        k_reg   <= '0;
                        brw_reg <= 1'b0;
                    end
                end
                S_SUB: begin
                    work_reg <= work_upd;
                    brw_reg  <= slice_bout;
                    k_reg    <= k_last ? '0 : k_reg + KW'(1);
                    if (k_last) begin
                        brw_reg <= 1'b0;
`ifdef SUB_SEQ_ABS_RESULT_EN
                        if (!slice_bout) begin
                            diff_reg   <= work_upd;
                            borrow_reg <= 1'b0;
                            neg_reg    <= 1'b0;
                        end
`else
                        diff_reg   <= work_upd;
                        borrow_reg <= slice_bout;
`endif
                    end
                end
`ifdef SUB_SEQ_ABS_RESULT_EN
                S_NEGATE: begin
                    work_reg <= work_upd;
                    brw_reg  <= slice_bout;
                    k_reg    <= k_last ? '0 : k_reg + KW'(1);
                    // Only entered when A<B, so the reported borrow is always 1 here.
                    if (k_last) begin
                        diff_reg   <= work_upd;
                        borrow_reg <= 1'b1;
                        neg_reg    <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_slice_sequencer.sv
// Bench for sub_slice_sequencer (WIDTH=9): arithmetic reference model checked every
// cycle, plus literal-expectation directed cases and a randomized phase.
module tb_sub_slice_sequencer;

    localparam int W  = 9;
    localparam int SL = W / 3;
    localparam int MASK = (1 << W) - 1;
`ifdef SUB_SEQ_ABS_RESULT_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b, diff;
    logic         busy, done, borrow_out, neg;
    logic [2:0]   slice_x, slice_y, slice_diff;
    logic         slice_bin, slice_bout;
    logic [3:0]   slice_t;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int sy [1:3];

    // Behavioural model state
    bit m_active = 1'b0;
    int m_cyc, m_lat, m_a, m_b;
    int m_diff = 0, m_borrow = 0, m_neg = 0;

    always #10 clk = ~clk;

    // External 3-bit ripple-borrow slice
    assign slice_t    = {1'b0, slice_x} - {1'b0, slice_y} - {3'b000, slice_bin};
    assign slice_diff = slice_t[2:0];
    assign slice_bout = slice_t[3];

    sub_slice_sequencer #(.WIDTH(W)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .neg(neg),
        .slice_x(slice_x), .slice_y(slice_y), .slice_bin(slice_bin),
        .slice_diff(slice_diff), .slice_bout(slice_bout)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int ex, ey, eb, j, w, md;
                ex = 0; ey = 0; eb = 0;
                if (m_active && m_cyc < m_lat) begin
                    if (m_cyc <= SL) begin
                        j  = m_cyc - 1;
                        md = 1 << (3 * j);
                        ex = (m_a >> (3 * j)) & 7;
                        ey = (m_b >> (3 * j)) & 7;
                        eb = ((m_a % md) < (m_b % md)) ? 1 : 0;
                    end else begin
                        j  = m_cyc - SL - 1;
                        md = 1 << (3 * j);
                        w  = (m_a - m_b) & MASK;
                        ey = (w >> (3 * j)) & 7;
                        eb = ((w % md) != 0) ? 1 : 0;
                    end
                end
                chk("busy", busy, m_active);
                chk("done", done, (m_active && m_cyc == m_lat) ? 1 : 0);
                chk("diff", diff, m_diff);
                chk("borrow_out", borrow_out, m_borrow);
                chk("neg", neg, m_neg);
                chk("slice_x", slice_x, ex);
                chk("slice_y", slice_y, ey);
                chk("slice_bin", slice_bin, eb);
            end
            if (reset) begin
                m_active = 1'b0;
                m_diff = 0; m_borrow = 0; m_neg = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_cyc = 1;
                    m_a = int'(a);
                    m_b = int'(b);
                    m_lat = (ABS && m_a < m_b) ? 2 * SL + 1 : SL + 1;
                end
            end else if (m_cyc == m_lat) begin
                m_active = 1'b0;
            end else begin
                m_cyc++;
                if (m_cyc == m_lat) begin
                    m_borrow = (m_a < m_b) ? 1 : 0;
                    m_neg    = (ABS && m_a < m_b) ? 1 : 0;
                    m_diff   = (ABS && m_a < m_b) ? (m_b - m_a) : ((m_a - m_b) & MASK);
                end
            end
        end
    end

    task automatic do_op(input int av, input int bv, input int ed, input int eb,
                         input int en, input int el, input string tag);
        int cyc;
        @(posedge clk); #2;
        a = W'(av); b = W'(bv); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 12) begin
            if (cyc <= 3) sy[cyc] = int'(slice_y);
            @(posedge clk); #2;
            cyc++;
        end
        chk({tag, " latency"}, cyc, el);
        chk({tag, " diff"}, diff, ed);
        chk({tag, " borrow"}, borrow_out, eb);
        chk({tag, " neg"}, neg, en);
        @(posedge clk); #2;
    endtask

    initial begin
        int dones, dcyc, ddiff;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        @(posedge clk); #2 chk_en = 1'b1;
        @(posedge clk); #2 reset = 1'b0;

        // 1. reset state
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst diff", diff, 0);
        chk("rst slice_x", slice_x, 0);
        chk("rst slice_y", slice_y, 0);
        chk("rst slice_bin", slice_bin, 0);

        // 2. 5-3
        do_op(5, 3, 2, 0, 0, 4, "5-3");
        chk("5-3 slice_y c1", sy[1], 3);
        chk("5-3 slice_y c2", sy[2], 0);
        chk("5-3 slice_y c3", sy[3], 0);

        // 3./4. negative results and boundaries
        if (ABS) begin
            do_op(3, 5, 2, 1, 1, 7, "3-5");
            do_op(0, 511, 511, 1, 1, 7, "0-511");
        end else begin
            do_op(3, 5, 9'h1FE, 1, 0, 4, "3-5");
            do_op(0, 511, 1, 1, 0, 4, "0-511");
        end
        do_op(511, 511, 0, 0, 0, 4, "511-511");
        if (ABS) do_op(0, 256, 256, 1, 1, 7, "0-256");
        else     do_op(0, 256, 256, 1, 0, 4, "0-256");

        // 5. start pulse while busy is ignored
        @(posedge clk); #2;
        a = 9'd200; b = 9'd100; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 start = 1'b1; a = 9'd7; b = 9'd1;
        @(posedge clk); #2 start = 1'b0;
        dones = 0; dcyc = 0; ddiff = -1;
        for (int c = 3; c <= 12; c++) begin
            if (done) begin
                dones++; dcyc = c; ddiff = int'(diff);
            end
            @(posedge clk); #2;
        end
        chk("busy-start dones", dones, 1);
        chk("busy-start done cycle", dcyc, 4);
        chk("busy-start diff", ddiff, 100);

        // 6. reset mid-operation
        @(posedge clk); #2;
        a = 9'd50; b = 9'd20; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort diff", diff, 0);
        do_op(8, 8, 0, 0, 0, 4, "8-8");

        // Randomized phase: start often held high, operands change freely, rare resets
        for (int c = 0; c < 1500; c++) begin
            int sel;
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) != 0);
            a = W'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = a;
            else if (sel == 1) b = '0;
            else if (sel == 2) b = '1;
            else               b = W'($urandom);
            reset = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        chk("final idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
